// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine for the 256x192 framebuffer write port: accepts one
// fill command, clips it to the screen and emits one pixel write per clock in raster order.
module fb_rect_fill #(
    parameter int FB_WIDTH   = 256,
    parameter int FB_HEIGHT  = 192,
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_SIZE  = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [8:0]            cmd_x,
    input  logic [8:0]            cmd_y,
    input  logic [8:0]            cmd_w,
    input  logic [8:0]            cmd_h,
    input  logic [WORD_SIZE-1:0]  cmd_color,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [WORD_SIZE-1:0]  write_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_CLIP, S_FILL, S_DONE} state_t;

    localparam logic [9:0] X_LIM = 10'(FB_WIDTH);
    localparam logic [9:0] Y_LIM = 10'(FB_HEIGHT);

    state_t                state_q;
    logic [8:0]            x_q, y_q, w_q, h_q;
    logic [WORD_SIZE-1:0]  color_q;
    logic [8:0]            cx_q, cy_q;
    logic [8:0]            cx_d, cy_d;
    logic                  ready_q, busy_q, done_q, we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_SIZE-1:0]  data_q;

    logic [9:0] x_sum, y_sum, x_end, y_end;
    logic       empty, row_last, col_last;

    // 10-bit sums so a 9-bit edge plus a 9-bit extent never wraps before clipping.
    assign x_sum    = {1'b0, x_q} + {1'b0, w_q};
    assign y_sum    = {1'b0, y_q} + {1'b0, h_q};
    assign x_end    = (x_sum > X_LIM) ? X_LIM : x_sum;
    assign y_end    = (y_sum > Y_LIM) ? Y_LIM : y_sum;
    assign empty    = (w_q == 9'd0) || (h_q == 9'd0) ||
                      ({1'b0, x_q} >= X_LIM) || ({1'b0, y_q} >= Y_LIM);
    assign row_last = ({1'b0, cx_q} + 10'd1) >= x_end;
    assign col_last = ({1'b0, cy_q} + 10'd1) >= y_end;
    assign cx_d     = row_last ? x_q : cx_q + 9'd1;
    assign cy_d     = row_last ? cy_q + 9'd1 : cy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        color_q <= cmd_color;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CLIP;
                    end
                end
                S_CLIP: begin
                    if (empty) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cx_q    <= x_q;
                        cy_q    <= y_q;
                        we_q    <= 1'b1;
                        addr_q  <= ADDR_WIDTH'({y_q[7:0], x_q[7:0]});
                        data_q  <= color_q;
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    // cx_q/cy_q track the pixel being written this cycle.
                    if (row_last && col_last) begin
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cx_q   <= cx_d;
                        cy_q   <= cy_d;
                        addr_q <= ADDR_WIDTH'({cy_d[7:0], cx_d[7:0]});
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign write_en   = we_q;
    assign write_addr = addr_q;
    assign write_data = data_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Scoreboard bench for fb_rect_fill: the driver pushes expected writes/done
// events from a loop-based clipping model; a negedge monitor pops and compares.
module tb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [17:0] cmd_color = '0;
    logic        write_en;
    logic [15:0] write_addr;
    logic [17:0] write_data;
    logic        busy;
    logic        done;

    fb_rect_fill #(
        .FB_WIDTH(256), .FB_HEIGHT(192), .ADDR_WIDTH(16), .WORD_SIZE(18)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 = pixel write, 1 = done pulse
        int          cyc;
        logic [15:0] addr;
        logic [17:0] data;
    } exp_t;

    exp_t        q[$];
    bit          busy_map[int];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] last_addr = '0;
    logic [17:0] last_data = '0;
    exp_t        me;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output observation is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_addr = '0;
            last_data = '0;
        end else begin
            chk("busy", 32'(busy), 32'(busy_map.exists(cyc) != 0));
            chk("cmd_ready", 32'(cmd_ready), 32'(busy_map.exists(cyc) == 0));
            if (write_en) begin
                if (q.size() == 0 || q[0].kind != 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr 0x%0h required no write (cycle %0d)", write_addr, cyc);
                end else begin
                    me = q.pop_front();
                    chk("write_cycle", 32'(cyc), 32'(me.cyc));
                    chk("write_addr", 32'(write_addr), 32'(me.addr));
                    chk("write_data", 32'(write_data), 32'(me.data));
                end
            end else begin
                chk("hold_addr", 32'(write_addr), 32'(last_addr));
                chk("hold_data", 32'(write_data), 32'(last_data));
            end
            if (done) begin
                if (q.size() == 0 || q[0].kind != 1) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 required 0 (cycle %0d)", cyc);
                end else begin
                    me = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(me.cyc));
                end
            end
            last_addr = write_addr;
            last_data = write_data;
        end
    end

    // Issue one command (called at a negedge); e returns the accepting edge index.
    task automatic issue(input int x, input int y, input int w, input int h,
                         input logic [17:0] col, input bit hold, output int e);
        int n, xe, ye, k;
        cmd_x = 9'(x); cmd_y = 9'(y); cmd_w = 9'(w); cmd_h = 9'(h);
        cmd_color = col;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 60000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            e = -1;
            return;
        end
        e  = cyc + 1;
        xe = (x + w > 256) ? 256 : x + w;
        ye = (y + h > 192) ? 192 : y + h;
        k  = 0;
        if (w > 0 && h > 0) begin
            for (int yy = y; yy < ye; yy++) begin
                for (int xx = x; xx < xe; xx++) begin
                    q.push_back('{0, e + 1 + k, 16'(yy * 256 + xx), col});
                    k++;
                end
            end
        end
        q.push_back('{1, e + 1 + k, 16'd0, 18'd0});
        for (int c = e; c <= e + 1 + k; c++) busy_map[c] = 1'b1;
        @(negedge clk);
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_x = 9'($urandom); cmd_y = 9'($urandom);
            cmd_w = 9'($urandom); cmd_h = 9'($urandom);
            cmd_color = 18'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !cmd_ready) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(q.size() == 0 && cmd_ready), 32'd1);
    endtask

    initial begin
        int e, e1, e2, n;
        int rx, ry, rw, rh;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(write_en), 32'd0);
        chk("rst_addr", 32'(write_addr), 32'd0);
        chk("rst_data", 32'(write_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic fill, edge clip, then the four empty forms.
        issue(10, 5, 2, 2, 18'h3FFFF, 1'b0, e);
        wait_idle();
        issue(250, 190, 10, 5, 18'h15A5A, 1'b0, e);
        wait_idle();
        issue(40, 40, 0, 7, 18'h00001, 1'b0, e);
        issue(40, 40, 7, 0, 18'h00002, 1'b0, e);
        issue(300, 40, 7, 7, 18'h00003, 1'b0, e);
        issue(40, 200, 7, 7, 18'h00004, 1'b0, e);
        wait_idle();

        // Back-to-back with cmd_valid held high.
        issue(100, 50, 1, 3, 18'h0ABCD, 1'b1, e1);
        issue(120, 60, 3, 1, 18'h1DCBA, 1'b0, e2);
        chk("b2b_accept_edge", 32'(e2 - e1), 32'd6);
        wait_idle();

        // Randomized commands, some straddling the right/bottom edges.
        for (int i = 0; i < 30; i++) begin
            rx = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 270) : $urandom_range(0, 300);
            ry = ($urandom_range(0, 3) == 0) ? $urandom_range(180, 200) : $urandom_range(0, 210);
            rw = $urandom_range(0, 24);
            rh = $urandom_range(0, 10);
            issue(rx, ry, rw, rh, 18'($urandom), 1'b0, e);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // Asynchronous reset during the third write of a 4x4 fill.
        issue(20, 30, 4, 4, 18'h2468A, 1'b0, e);
        n = 0;
        while (cyc != e + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(write_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        q.delete();
        busy_map.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        issue(0, 0, 1, 1, 18'h13579, 1'b0, e);
        wait_idle();

        // Full-screen clear.
        issue(0, 0, 256, 192, 18'h00000, 1'b0, e);
        wait_idle();

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
